serial_chain_tx: RTL and testbench
==================================

// Module: serial_chain_tx
// PURPOSE
//   Parallel-to-serial transmitter that drives the serial shift chain: produces the serial data
//   bit and the shift-enable strobe the chain's shifter consumes. Accepts DATA_W-bit words over a
//   valid/ready handshake, buffers one word, serialises each word at a programmable bit rate and
//   inserts a programmable idle gap between words. Sits in the fabric next to the chain, on clk.
// PARAMETERS
//   DATA_W     16  word width in bits; legal range >=2
//   DIV        4   clk cycles per bit period; legal range >=1
//   GAP        2   idle bit periods between words; legal range >=0
//   MSB_FIRST  1   1: bit DATA_W-1 is sent first; 0: bit 0 is sent first
// PORTS
//   clk         in   1       system clock; all logic is on the rising edge
//   rst_n       in   1       asynchronous, active-low reset
//   s_data      in   DATA_W  word to transmit
//   s_valid     in   1       s_data is valid
//   s_ready     out  1       block can accept a word; a word is accepted when s_valid & s_ready
//   ser_out     out  1       serial data, drives the chain data input
//   shift_en    out  1       one-cycle strobe per bit, drives the chain shift enable
//   busy        out  1       high in SHIFT and GAP
//   frame_done  out  1       one-cycle pulse when the last bit's shift_en fires
// BEHAVIOUR
//   Reset (async assert): ser_out=0, shift_en=0, busy=0, frame_done=0, s_ready=1,
//     hold buffer emptied, state IDLE. Release is synchronous to clk.
//   States:
//     IDLE -> SHIFT on accept. The word loads straight into the shift register.
//       ser_out shows the first bit in the cycle after the accepting edge.
//     SHIFT: each bit is held on ser_out for exactly DIV cycles. shift_en is high in the last
//       (DIV-th) cycle of each bit period. DIV=1 gives shift_en high every SHIFT cycle.
//       After DATA_W bits -> GAP (GAP>0), or -> load/IDLE (GAP=0).
//     GAP: lasts GAP*DIV cycles with ser_out=0 and shift_en=0. At the end it loads the hold word
//       and goes to SHIFT if one is present, otherwise goes to IDLE.
//   Hold buffer: one entry, so s_ready = !hold_full. An accept outside IDLE writes the hold buffer.
//     If a load and an accept happen in the same cycle, the load empties the hold buffer and the
//     accepted word refills it.
//   Throughput: back-to-back words take (DATA_W+GAP)*DIV cycles each, with no extra idle cycle.
//   frame_done is coincident with the final shift_en of a word.
//   While s_ready=0, s_valid may stay high. s_data is ignored unless accepted.
//   Reset mid-frame: immediate abort. No further shift_en, no frame_done, the held word is
//     discarded.
//   Parameter checks at elaboration: DATA_W<2 or DIV<1 is a fatal error.
// STRUCTURE
//   Package serial_chain_pkg:
//     state enum {IDLE, SHIFT, GAP}
//     localparam widths: BIT_CNT_W=$clog2(DATA_W), DIV_CNT_W=$clog2(DIV+1), GAP_CNT_W
//   One sub-module, bit_rate_timer: DIV-cycle counter. It restarts on load and emits a tick in
//     the last cycle of each bit period; the FSM uses the tick for shift_en and bit/gap counting.
//   FSM, shift register, bit counter, gap counter and hold buffer live in serial_chain_tx.
// TESTING (DATA_W=8, DIV=4, GAP=2, MSB_FIRST=1 unless stated)
//   1. Hold rst_n=0 for 5 cycles, release -> s_ready=1, all other outputs 0. No shift_en for
//      20 idle cycles.
//   2. Single word 0xA5 -> ser_out runs 1,0,1,0,0,1,0,1, each bit 4 cycles. shift_en pulses 8x,
//      on cycle 4 of each bit. One frame_done with the 8th pulse. busy high for 40 cycles.
//   3. Words 0x3C then 0xC3 with s_valid held high -> the second word is accepted during the
//      first frame. Its first bit appears exactly 40 cycles after the first word's first bit.
//      80 busy cycles total.
//   4. Three words offered back-to-back -> s_ready drops after the second accept and stays low
//      until the second word loads. The third is then accepted. All three are serialised intact,
//      in order.
//   5. MSB_FIRST=0, DIV=1, GAP=0, word 0x01 -> ser_out 1 then seven 0s, one bit per cycle.
//      shift_en high for 8 consecutive cycles.
//   6. Assert rst_n after 3 bits of 0xFF -> outputs return to reset values immediately.
//      frame_done never pulses. The next word after release is transmitted in full.

Source files
------------

// File: rtl/serial_chain_pkg.sv
// Shared state type and counter-width helper for the serial chain transmitter.
package serial_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int cntWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_chain_tx_bit_rate_timer.sv
// Bit-period timer for the serial chain transmitter: counts DIV clocks and flags the last one.
module bit_rate_timer
    import serial_chain_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_restart,
    input  logic i_enable,
    output logic o_tick
);

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == CNT_W'(DIV - 1));
    assign o_tick = i_enable && w_last;

    // A restart always begins a fresh bit period, even if it lands on a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_restart) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_last ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_chain_tx.sv
// Parallel-to-serial transmitter feeding the shift chain: one-word hold buffer, programmable
// bit rate and inter-word gap, with a shift-enable strobe on the last cycle of every bit.
module serial_chain_tx
    import serial_chain_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DIV       = 4,
    parameter int GAP       = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ser_out,
    output logic              shift_en,
    output logic              busy,
    output logic              frame_done
);

    localparam int BIT_CNT_W = cntWidth(DATA_W);
    localparam int DIV_CNT_W = cntWidth(DIV + 1);
    localparam int GAP_CNT_W = cntWidth(GAP);
    localparam int OUT_BIT   = (MSB_FIRST != 0) ? DATA_W - 1 : 0;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);
    localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

    if (DATA_W < 2 || DIV < 1 || GAP < 0) begin : g_badParams
        $fatal(1, "serial_chain_tx: illegal parameters (need DATA_W>=2, DIV>=1, GAP>=0)");
    end

    state_t                 r_state;
    logic [DATA_W-1:0]      r_shift;
    logic [DATA_W-1:0]      r_holdData;
    logic                   r_holdFull;
    logic [BIT_CNT_W-1:0]   r_bitCnt;
    logic [GAP_CNT_W-1:0]   r_gapCnt;

    logic                   w_tick;
    logic                   w_accept;
    logic                   w_lastBit;
    logic                   w_gapDone;
    logic                   w_frameEnd;
    logic                   w_takeDirect;
    logic                   w_load;
    logic [DATA_W-1:0]      w_loadData;

    bit_rate_timer #(
        .DIV   (DIV),
        .CNT_W (DIV_CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_load),
        .i_enable  (r_state != ST_IDLE),
        .o_tick    (w_tick)
    );

    // A word offered exactly as a frame ends with an empty buffer goes straight into the
    // shifter, so the chain never sees a lost cycle or a stuck full buffer in IDLE.
    always_comb begin
        w_accept     = s_valid && !r_holdFull;
        w_lastBit    = (r_state == ST_SHIFT) && w_tick && (r_bitCnt == LAST_BIT);
        w_gapDone    = (r_state == ST_GAP) && w_tick && (r_gapCnt == LAST_GAP);
        w_frameEnd   = (GAP == 0) ? w_lastBit : w_gapDone;
        w_takeDirect = w_accept && ((r_state == ST_IDLE) || w_frameEnd);
        w_load       = w_takeDirect || (w_frameEnd && r_holdFull);
        w_loadData   = r_holdFull ? r_holdData : s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_holdData <= '0;
            r_holdFull <= 1'b0;
            r_bitCnt   <= '0;
            r_gapCnt   <= '0;
        end else begin
            if (w_accept && !w_takeDirect) begin
                r_holdFull <= 1'b1;
                r_holdData <= s_data;
            end else if (w_load) begin
                r_holdFull <= 1'b0;
            end

            if (w_load) begin
                r_state  <= ST_SHIFT;
                r_shift  <= w_loadData;
                r_bitCnt <= '0;
            end else begin
                case (r_state)
                    ST_SHIFT: begin
                        if (w_tick) begin
                            if (r_bitCnt == LAST_BIT) begin
                                if (GAP > 0) begin
                                    r_state  <= ST_GAP;
                                    r_gapCnt <= '0;
                                end else begin
                                    r_state <= ST_IDLE;
                                end
                            end else begin
                                if (MSB_FIRST != 0) begin
                                    r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                                end else begin
                                    r_shift <= {1'b0, r_shift[DATA_W-1:1]};
                                end
                                r_bitCnt <= r_bitCnt + BIT_CNT_W'(1);
                            end
                        end
                    end
                    ST_GAP: begin
                        if (w_tick) begin
                            if (r_gapCnt == LAST_GAP) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_gapCnt <= r_gapCnt + GAP_CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign s_ready    = !r_holdFull;
    assign ser_out    = (r_state == ST_SHIFT) && r_shift[OUT_BIT];
    assign shift_en   = (r_state == ST_SHIFT) && w_tick;
    assign frame_done = w_lastBit;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_chain_tx.sv
// Self-checking bench for serial_chain_tx: timing-level reference model plus a serial scoreboard.
`timescale 1ns/1ps
module tb_serial_chain_tx;

    localparam int W         = 8;
    localparam int D         = 4;
    localparam int G         = 2;
    localparam int BITS_CYC  = W * D;
    localparam int FRAME_CYC = (W + G) * D;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready, ser_out, shift_en, busy, frame_done;

    logic [7:0] s_data5;
    logic       s_valid5;
    logic       s_ready5, ser_out5, shift_en5, busy5, frame_done5;

    always #5 clk = ~clk;

    serial_chain_tx #(.DATA_W(8), .DIV(4), .GAP(2), .MSB_FIRST(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .ser_out    (ser_out),
        .shift_en   (shift_en),
        .busy       (busy),
        .frame_done (frame_done)
    );

    serial_chain_tx #(.DATA_W(8), .DIV(1), .GAP(0), .MSB_FIRST(0)) dutLsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data5),
        .s_valid    (s_valid5),
        .s_ready    (s_ready5),
        .ser_out    (ser_out5),
        .shift_en   (shift_en5),
        .busy       (busy5),
        .frame_done (frame_done5)
    );

    int         checkCount = 0;
    int         errorCount = 0;
    int         cycleNo = 0;

    // Reference model: a frame is a start cycle plus a word; everything else is arithmetic.
    bit         mdlActive;
    bit         mdlHoldFull;
    int         mdlStart;
    logic [7:0] mdlWord;
    logic [7:0] mdlHold;
    logic [7:0] rxExpQ[$];
    logic [7:0] rxWord;
    int         rxBits;
    bit         lastAccept;

    int         shiftCnt, fdCnt, busyCnt, readyLowCnt;
    int         fdTimes[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cycleNo);
        end
    endtask

    task automatic modelReset();
        mdlActive   = 1'b0;
        mdlHoldFull = 1'b0;
        rxExpQ.delete();
        rxBits = 0;
        rxWord = '0;
    endtask

    task automatic resetStats();
        shiftCnt    = 0;
        fdCnt       = 0;
        busyCnt     = 0;
        readyLowCnt = 0;
        fdTimes.delete();
    endtask

    // One clock: check this cycle's outputs mid-cycle, then drive inputs for the coming edge.
    task automatic stepCycle(input logic v, input logic [7:0] d);
        int   off;
        logic eSer, eSh, eFd, eBusy, eRdy;
        bit   acc;
        @(negedge clk);
        off   = cycleNo - mdlStart;
        eSer  = 1'b0;
        eSh   = 1'b0;
        eFd   = 1'b0;
        eBusy = mdlActive;
        eRdy  = !mdlHoldFull;
        if (mdlActive && off < BITS_CYC) begin
            eSer = mdlWord[W - 1 - off / D];
            eSh  = ((off % D) == D - 1);
            eFd  = eSh && (off / D == W - 1);
        end
        checkOutput("ser_out", 32'(ser_out), 32'(eSer));
        checkOutput("shift_en", 32'(shift_en), 32'(eSh));
        checkOutput("frame_done", 32'(frame_done), 32'(eFd));
        checkOutput("busy", 32'(busy), 32'(eBusy));
        checkOutput("s_ready", 32'(s_ready), 32'(eRdy));

        if (shift_en) begin
            shiftCnt++;
            rxWord = {rxWord[6:0], ser_out};
            rxBits++;
            if (rxBits == W) begin
                if (rxExpQ.size() > 0) checkOutput("rx word", 32'(rxWord), 32'(rxExpQ.pop_front()));
                else checkOutput("rx unexpected word", 32'(rxExpQ.size()), 32'd1);
                rxBits = 0;
            end
        end
        if (frame_done) begin
            fdCnt++;
            fdTimes.push_back(cycleNo);
        end
        if (busy) busyCnt++;
        if (!s_ready) readyLowCnt++;

        s_valid    = v;
        s_data     = d;
        lastAccept = 1'b0;
        if (rst_n) begin
            acc = v && !mdlHoldFull;
            if (acc) begin
                rxExpQ.push_back(d);
                lastAccept = 1'b1;
            end
            if (!mdlActive) begin
                if (acc) begin
                    mdlActive = 1'b1; mdlWord = d; mdlStart = cycleNo + 1;
                end
            end else if (off == FRAME_CYC - 1) begin
                if (mdlHoldFull) begin
                    mdlWord = mdlHold; mdlStart = cycleNo + 1; mdlHoldFull = 1'b0;
                end else if (acc) begin
                    mdlWord = d; mdlStart = cycleNo + 1;
                end else begin
                    mdlActive = 1'b0;
                end
            end else if (acc) begin
                mdlHoldFull = 1'b1;
                mdlHold     = d;
            end
        end
        cycleNo++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle(1'b0, 8'($urandom));
    endtask

    task automatic applyStimulus(input logic [7:0] d);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            stepCycle(1'b1, d);
            got = lastAccept;
        end
        checkOutput("accept", 32'(got), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < FRAME_CYC * 3 && mdlActive; i++) stepCycle(1'b0, 8'($urandom));
        idleCycles(2);
        checkOutput("drain busy", 32'(busy), 32'd0);
        checkOutput("rx queue empty", 32'(rxExpQ.size()), 32'd0);
    endtask

    task automatic checkLsbWord(input logic [7:0] w);
        @(negedge clk);
        checkOutput("lsb s_ready", 32'(s_ready5), 32'd1);
        s_valid5 = 1'b1;
        s_data5  = w;
        @(negedge clk);
        s_valid5 = 1'b0;
        s_data5  = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            checkOutput("lsb ser_out", 32'(ser_out5), 32'(w[i]));
            checkOutput("lsb shift_en", 32'(shift_en5), 32'd1);
            checkOutput("lsb frame_done", 32'(frame_done5), 32'(i == 7));
            @(negedge clk);
        end
        checkOutput("lsb busy after", 32'(busy5), 32'd0);
        checkOutput("lsb shift_en after", 32'(shift_en5), 32'd0);
    endtask

    initial begin
        s_valid  = 1'b0;
        s_data   = '0;
        s_valid5 = 1'b0;
        s_data5  = '0;
        rst_n    = 1'b1;
        modelReset();
        resetStats();
        #1 rst_n = 1'b0;

        $display("[TB] reset and idle");
        idleCycles(5);
        rst_n = 1'b1;
        idleCycles(20);
        checkOutput("idle shift_en count", 32'(shiftCnt), 32'd0);

        $display("[TB] single word 0xA5");
        resetStats();
        applyStimulus(8'hA5);
        drain();
        checkOutput("A5 shift_en count", 32'(shiftCnt), 32'd8);
        checkOutput("A5 frame_done count", 32'(fdCnt), 32'd1);
        checkOutput("A5 busy cycles", 32'(busyCnt), 32'd40);

        $display("[TB] two words back-to-back");
        resetStats();
        applyStimulus(8'h3C);
        applyStimulus(8'hC3);
        drain();
        checkOutput("pair busy cycles", 32'(busyCnt), 32'd80);
        if (fdTimes.size() == 2) checkOutput("pair frame spacing", 32'(fdTimes[1] - fdTimes[0]), 32'd40);
        else checkOutput("pair frame count", 32'(fdTimes.size()), 32'd2);

        $display("[TB] three words back-to-back");
        resetStats();
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        drain();
        checkOutput("triple frame_done count", 32'(fdCnt), 32'd3);
        checkOutput("triple s_ready low cycles", 32'(readyLowCnt), 32'd78);

        $display("[TB] LSB-first, DIV=1, GAP=0");
        checkLsbWord(8'h01);
        for (int n = 0; n < 4; n++) checkLsbWord(8'($urandom));

        $display("[TB] reset mid-frame");
        resetStats();
        applyStimulus(8'hFF);
        for (int i = 0; i < 100 && shiftCnt < 3; i++) stepCycle(1'b0, 8'($urandom));
        checkOutput("abort point", 32'(shiftCnt), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort ser_out", 32'(ser_out), 32'd0);
        checkOutput("abort shift_en", 32'(shift_en), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort frame_done", 32'(frame_done), 32'd0);
        checkOutput("abort s_ready", 32'(s_ready), 32'd1);
        modelReset();
        idleCycles(3);
        rst_n = 1'b1;
        idleCycles(10);
        checkOutput("abort no frame_done", 32'(fdCnt), 32'd0);
        checkOutput("abort no more shifts", 32'(shiftCnt), 32'd3);
        applyStimulus(8'h96);
        drain();
        checkOutput("post-abort frame_done", 32'(fdCnt), 32'd1);

        $display("[TB] randomized traffic");
        resetStats();
        for (int n = 0; n < 40; n++) begin
            applyStimulus(8'($urandom));
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 60));
        end
        drain();
        checkOutput("random frame_done count", 32'(fdCnt), 32'd40);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
